// File: rtl/quad_gen.sv
// quad_gen: quadrature edge generator. Accepts a move command of N edges at
// a fixed edge period and direction, drives quadA/quadB and a wrapping
// position count in 0..1496.
// Optional feature: define QUAD_GEN_INDEX_EN to add the o_index output
// (high while the position is 0 and AB is 00).
module quad_gen (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_cmd_valid,
   input  logic [15:0] i_cmd_steps,
   input  logic [15:0] i_cmd_period,
   input  logic        i_cmd_dir,
   input  logic        i_abort,
   output logic        o_cmd_ready,
   output logic        quadA,
   output logic        quadB,
   output logic [15:0] o_count,
   output logic        o_busy,
   output logic        o_done
`ifdef QUAD_GEN_INDEX_EN
   ,
   output logic        o_index
`endif
);

   localparam int unsigned CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1496);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_steps;
   logic [CNT_W-1:0]   r_period;
   logic [CNT_W-1:0]   r_per_cnt;
   logic               r_dir;
   logic               r_a;
   logic               r_b;
   logic [CNT_W-1:0]   r_count;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;
   logic               r_index;

   logic               w_accept;
   logic [CNT_W-1:0]   w_eff_period;
   logic               w_a_nxt;
   logic               w_b_nxt;
   logic [CNT_W-1:0]   w_count_nxt;
   logic               w_index_nxt;

   // Command handshake and effective period (a period of 0 behaves as 1).
   assign w_accept     = i_cmd_valid & r_ready;
   assign w_eff_period = (i_cmd_period == '0) ? CNT_W'(1) : i_cmd_period;

   // Next quadrature state: forward 00->10->11->01, reverse 00->01->11->10.
   assign w_a_nxt = r_dir ? ~r_b : r_b;
   assign w_b_nxt = r_dir ? r_a  : ~r_a;

   // Next position with wrap at both ends of 0..1496.
   assign w_count_nxt = r_dir ? ((r_count == CNT_MAX) ? '0 : r_count + CNT_W'(1))
                              : ((r_count == '0) ? CNT_MAX : r_count - CNT_W'(1));

   assign w_index_nxt = (w_count_nxt == '0) & ~w_a_nxt & ~w_b_nxt;

   // Move sequencer: command latch, period timing, edge emission, abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_steps   <= '0;
         r_period  <= '0;
         r_per_cnt <= '0;
         r_dir     <= 1'b0;
         r_a       <= 1'b0;
         r_b       <= 1'b0;
         r_count   <= '0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_index   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_dir    <= i_cmd_dir;
                  r_period <= w_eff_period;
                  if (i_cmd_steps == '0) begin
                     // Empty move: finish at once without leaving IDLE.
                     r_done <= 1'b1;
                  end else begin
                     r_steps   <= i_cmd_steps;
                     r_per_cnt <= w_eff_period;
                     r_state   <= RUN;
                     r_ready   <= 1'b0;
                     r_busy    <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (i_abort) begin
                  // Abort beats any edge scheduled for this clock.
                  r_state   <= IDLE;
                  r_ready   <= 1'b1;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_steps   <= '0;
                  r_per_cnt <= '0;
               end else if (r_per_cnt == CNT_W'(1)) begin
                  r_per_cnt <= r_period;
                  r_a       <= w_a_nxt;
                  r_b       <= w_b_nxt;
                  r_count   <= w_count_nxt;
                  r_index   <= w_index_nxt;
                  r_steps   <= r_steps - CNT_W'(1);
                  if (r_steps == CNT_W'(1)) begin
                     r_state   <= IDLE;
                     r_ready   <= 1'b1;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                     r_per_cnt <= '0;
                  end
               end else begin
                  r_per_cnt <= r_per_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_cmd_ready = r_ready;
   assign quadA       = r_a;
   assign quadB       = r_b;
   assign o_count     = r_count;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
`ifdef QUAD_GEN_INDEX_EN
   assign o_index     = r_index;
`endif

endmodule

// File: tb/tb_quad_gen.sv
// tb_quad_gen: directed bench for quad_gen with hand-computed edge tables
// and a small quadrature decoder for the full-revolution move.
module tb_quad_gen;

   logic        clk;
   logic        rst_n;
   logic        i_cmd_valid;
   logic [15:0] i_cmd_steps;
   logic [15:0] i_cmd_period;
   logic        i_cmd_dir;
   logic        i_abort;
   logic        o_cmd_ready;
   logic        quadA;
   logic        quadB;
   logic [15:0] o_count;
   logic        o_busy;
   logic        o_done;
`ifdef QUAD_GEN_INDEX_EN
   logic        o_index;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [1:0] e_ab;

   quad_gen u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_cmd_valid  (i_cmd_valid),
      .i_cmd_steps  (i_cmd_steps),
      .i_cmd_period (i_cmd_period),
      .i_cmd_dir    (i_cmd_dir),
      .i_abort      (i_abort),
      .o_cmd_ready  (o_cmd_ready),
      .quadA        (quadA),
      .quadB        (quadB),
      .o_count      (o_count),
      .o_busy       (o_busy),
      .o_done       (o_done)
`ifdef QUAD_GEN_INDEX_EN
      ,
      .o_index      (o_index)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a command for exactly one accepting edge, then scramble the inputs.
   task automatic issue(input logic [15:0] steps, input logic [15:0] period, input logic dir);
      i_cmd_valid  = 1'b1;
      i_cmd_steps  = steps;
      i_cmd_period = period;
      i_cmd_dir    = dir;
      step();
      i_cmd_valid  = 1'b0;
      i_cmd_steps  = 16'hFFFF;
      i_cmd_period = 16'h0007;
      i_cmd_dir    = ~dir;
   endtask

   // Expect AB to hold for p-1 clocks, then the given edge on the p-th clock.
   task automatic edge_chk(input string tag, input int p, input logic [1:0] ab,
                           input logic [15:0] cnt, input logic last);
      for (int i = 1; i < p; i++) begin
         step();
         chk({tag, "_hold"}, {quadA, quadB}, e_ab);
         chk({tag, "_busy"}, o_busy, 1'b1);
      end
      step();
      chk({tag, "_ab"},   {quadA, quadB}, ab);
      chk({tag, "_cnt"},  o_count, cnt);
      chk({tag, "_done"}, o_done, last);
      chk({tag, "_rdy"},  o_cmd_ready, last);
      e_ab = ab;
   endtask

   // 1497-edge forward move watched by an independent quadrature decoder.
   task automatic run_long(input string tag, input logic [15:0] cnt_exp, input logic [1:0] ab_exp);
      int dec = 0;
      int edges = 0;
      int bad = 0;
      int cyc = 0;
      bit fin = 1'b0;
      logic [1:0] prev;
      logic [1:0] cur;
      prev = {quadA, quadB};
      issue(16'd1497, 16'd1, 1'b1);
      while (!fin && cyc < 2000) begin
         step();
         cyc++;
         cur = {quadA, quadB};
         if (cur != prev) begin
            edges++;
            if (cur == {~prev[0], prev[1]})      dec = (dec + 1) % 1497;
            else if (cur == {prev[0], ~prev[1]}) dec = (dec + 1496) % 1497;
            else                                  bad++;
            prev = cur;
         end
         if (o_done) fin = 1'b1;
      end
      chk({tag, "_finished"}, fin, 1'b1);
      chk({tag, "_cycles"}, cyc, 1497);
      chk({tag, "_edges"}, edges, 1497);
      chk({tag, "_illegal"}, bad, 0);
      chk({tag, "_dec_return"}, dec, 0);
      chk({tag, "_cnt"}, o_count, cnt_exp);
      chk({tag, "_ab"}, {quadA, quadB}, ab_exp);
      e_ab = ab_exp;
   endtask

   initial begin
      rst_n        = 1'b0;
      i_cmd_valid  = 1'b0;
      i_cmd_steps  = '0;
      i_cmd_period = '0;
      i_cmd_dir    = 1'b0;
      i_abort      = 1'b0;
      e_ab         = 2'b00;

      // Reset state.
      step();
      step();
      chk("rst_ab",   {quadA, quadB}, 2'b00);
      chk("rst_cnt",  o_count, 16'd0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_done", o_done, 1'b0);
      #4 rst_n = 1'b1;
      step();
      chk("rst_rdy", o_cmd_ready, 1'b1);
`ifdef QUAD_GEN_INDEX_EN
      chk("rst_idx", o_index, 1'b0);
`endif

      // Forward 4 edges, period 3.
      issue(16'd4, 16'd3, 1'b1);
      chk("t1_busy", o_busy, 1'b1);
      chk("t1_rdy0", o_cmd_ready, 1'b0);
      edge_chk("t1e1", 3, 2'b10, 16'd1, 1'b0);
      edge_chk("t1e2", 3, 2'b11, 16'd2, 1'b0);
      edge_chk("t1e3", 3, 2'b01, 16'd3, 1'b0);
      edge_chk("t1e4", 3, 2'b00, 16'd4, 1'b1);
      chk("t1_idle", o_busy, 1'b0);
      step();
      chk("t1_done_clr", o_done, 1'b0);

      // Reverse 4 edges, period 1, back to position 0.
      issue(16'd4, 16'd1, 1'b0);
      edge_chk("t2e1", 1, 2'b01, 16'd3, 1'b0);
      edge_chk("t2e2", 1, 2'b11, 16'd2, 1'b0);
      edge_chk("t2e3", 1, 2'b10, 16'd1, 1'b0);
      edge_chk("t2e4", 1, 2'b00, 16'd0, 1'b1);
`ifdef QUAD_GEN_INDEX_EN
      chk("t2_idx", o_index, 1'b1);
`endif
      step();

      // Reverse through the low wrap, period 0 acting as 1.
      issue(16'd2, 16'd0, 1'b0);
      edge_chk("t3e1", 1, 2'b01, 16'd1496, 1'b0);
`ifdef QUAD_GEN_INDEX_EN
      chk("t3_idx", o_index, 1'b0);
`endif
      edge_chk("t3e2", 1, 2'b11, 16'd1495, 1'b1);
      step();

      // Full revolution from 1495: position returns, AB phase advances by one.
      run_long("t4", 16'd1495, 2'b01);
      step();

      // Forward through the high wrap, period 2.
      issue(16'd3, 16'd2, 1'b1);
      edge_chk("t5e1", 2, 2'b00, 16'd1496, 1'b0);
      edge_chk("t5e2", 2, 2'b10, 16'd0, 1'b0);
`ifdef QUAD_GEN_INDEX_EN
      chk("t5_idx", o_index, 1'b0);
`endif
      edge_chk("t5e3", 2, 2'b11, 16'd1, 1'b1);
      step();

      // Abort 12 clocks into a 100-step move at period 5.
      issue(16'd100, 16'd5, 1'b1);
      edge_chk("t6e1", 5, 2'b01, 16'd2, 1'b0);
      edge_chk("t6e2", 5, 2'b00, 16'd3, 1'b0);
      step();
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      chk("t6_done", o_done, 1'b1);
      chk("t6_busy", o_busy, 1'b0);
      chk("t6_rdy", o_cmd_ready, 1'b1);
      chk("t6_cnt", o_count, 16'd3);
      repeat (6) step();
      chk("t6_done_clr", o_done, 1'b0);
      chk("t6_ab_hold", {quadA, quadB}, 2'b00);
      chk("t6_cnt_hold", o_count, 16'd3);

      // Abort on the very clock an edge is due: no edge.
      issue(16'd5, 16'd2, 1'b1);
      edge_chk("t7e1", 2, 2'b10, 16'd4, 1'b0);
      step();
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      chk("t7_ab", {quadA, quadB}, 2'b10);
      chk("t7_cnt", o_count, 16'd4);
      chk("t7_done", o_done, 1'b1);

      // Abort while idle is ignored.
      step();
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      chk("t8_busy", o_busy, 1'b0);
      chk("t8_done", o_done, 1'b0);
      chk("t8_rdy", o_cmd_ready, 1'b1);

      // Zero-step command.
      issue(16'd0, 16'd7, 1'b1);
      chk("t9_done", o_done, 1'b1);
      chk("t9_busy", o_busy, 1'b0);
      chk("t9_rdy", o_cmd_ready, 1'b1);
      chk("t9_ab", {quadA, quadB}, 2'b10);
      step();
      chk("t9_done_clr", o_done, 1'b0);
      step();
      chk("t9_cnt", o_count, 16'd4);

      // Reset in the middle of a move.
      issue(16'd10, 16'd2, 1'b1);
      edge_chk("t10e1", 2, 2'b11, 16'd5, 1'b0);
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("t10_ab", {quadA, quadB}, 2'b00);
      chk("t10_cnt", o_count, 16'd0);
      chk("t10_busy", o_busy, 1'b0);
      chk("t10_done", o_done, 1'b0);
      step();
      step();
      #2 rst_n = 1'b1;
      step();
      chk("t10_rdy", o_cmd_ready, 1'b1);
      step();
      chk("t10_done_after", o_done, 1'b0);
      chk("t10_cnt_after", o_count, 16'd0);
      e_ab = 2'b00;

      // Full revolution from 0 returns to 0.
      run_long("t11", 16'd0, 2'b10);
`ifdef QUAD_GEN_INDEX_EN
      chk("t11_idx", o_index, 1'b0);
`endif
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
